instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order word requests to
// instruction memory, buffers returned words in a DEPTH-entry FIFO and hands
// them to decode under valid/ready. Redirects flush the FIFO and squash any
// responses still in flight.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to flag misaligned redirect
// targets and halt fetch until the next aligned redirect.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0] outstanding_q, outstanding_d, drop_q, drop_d;
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   tag_q        [DEPTH];

    logic [CW-1:0] occupancy;
    logic [CW+1:0] credit_used;
    logic          halted;
    logic          req_fire, rsp_take, rsp_drop, push, pop;

    assign occupancy   = wr_ptr_q - rd_ptr_q;
    assign credit_used = {2'b00, occupancy} + {2'b00, outstanding_q} + {2'b00, drop_q};

    assign imem_req_valid = !rst && !redirect_valid && !halted &&
                            (credit_used < (CW + 2)'(DEPTH));
    assign imem_addr      = fetch_pc_q;

    assign instr_valid = (wr_ptr_q != rd_ptr_q);
    assign instr       = fifo_instr_q[rd_ptr_q[AW-1:0]];
    assign pc          = fifo_pc_q[rd_ptr_q[AW-1:0]];

    assign req_fire = imem_req_valid && imem_req_ready;
    // Responses arriving with nothing in flight are stray and ignored.
    assign rsp_take = imem_rsp_valid && ((drop_q != '0) || (outstanding_q != '0));
    // A response coinciding with a redirect is squashed along with the rest.
    assign rsp_drop = rsp_take && (redirect_valid || (drop_q != '0));
    assign push     = rsp_take && !rsp_drop;
    assign pop      = instr_valid && instr_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    // Sticky misalign flag, rewritten by every redirect.
    always_comb begin
        misalign_d = misalign_q;
        if (redirect_valid) begin
            misalign_d = |redirect_pc[1:0];
        end
    end

    // Misalign flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign halted         = misalign_q;
    assign fetch_misalign = misalign_q;
`else
    logic unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_pc[1:0];
    assign halted             = 1'b0;
    assign fetch_misalign     = 1'b0;
`endif

    // Next-state for PC, pointers and in-flight counters.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        outstanding_d = outstanding_q + {{(CW-1){1'b0}}, req_fire} - {{(CW-1){1'b0}}, push};
        drop_d        = drop_q - {{(CW-1){1'b0}}, rsp_take && (drop_q != '0)};
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_wr_d   = tag_wr_q + 1'b1;
        end
        // Squashed responses still consume their tag to keep the queue aligned.
        if (rsp_take) begin
            tag_rd_d = tag_rd_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (redirect_valid) begin
            rd_ptr_d      = wr_ptr_q;
            wr_ptr_d      = wr_ptr_q;
            drop_d        = drop_q + outstanding_q - {{(CW-1){1'b0}}, rsp_take};
            outstanding_d = '0;
            fetch_pc_d    = {redirect_pc[31:2], 2'b00};
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Instruction buffer storage; cleared on reset so instr/pc read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else if (push) begin
            fifo_pc_q[wr_ptr_q[AW-1:0]]    <= tag_q[tag_rd_q[AW-1:0]];
            fifo_instr_q[wr_ptr_q[AW-1:0]] <= imem_rsp_data;
        end
    end

    // In-order queue of issued addresses used to tag returning words.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr_q[AW-1:0]] <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fixed-latency memory model.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h3E80_8093;
        return a ^ 32'hA5A5_0013;
    endfunction

    // Memory model: fixed latency, in order, one response per cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t mq[$];
    int       cyc       = 0;
    int       lat       = 1;
    int       req_count = 0;

    always @(posedge clk) begin
        if (rst) begin
            req_count <= 0;
        end else if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_addr, due: cyc + lat});
            req_count <= req_count + 1;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mem_word(mq[0].addr);
            mq.pop_front();
        end else begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'hDEAD_BEEF;
        end
    end

    task automatic do_reset(input int l, input logic rdy);
        rst            = 1'b1;
        lat            = l;
        imem_req_ready = rdy;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits up to 20 cycles for a valid word; returns 1 if one appeared.
    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst            = 1'b1;
        lat            = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        @(negedge clk);
        @(negedge clk);
        checks += 6;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
        if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
        if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc); end
        if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b want 0", fetch_misalign); end
        rst = 1'b0;
        #1;
        checks += 2;
        if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %b want 1", imem_req_valid); end
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr got %h want 0", imem_addr); end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL early_valid got %b want 0", instr_valid); end
        @(negedge clk);
        checks += 3;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", instr_valid); end
        if (pc !== 32'h0) begin errors++; $display("FAIL first_pc got %h want 0", pc); end
        if (instr !== 32'h3E80_8093) begin errors++; $display("FAIL first_instr got %h want 3e808093", instr); end
    endtask

    task automatic test_stream;
        bit seen;
        do_reset(1, 1'b1);
        instr_ready = 1'b1;
        wait_valid(seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL stream_timeout got no valid want valid"); end
        for (int k = 0; k < 5; k++) begin
            checks += 3;
            if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", k, instr_valid); end
            if (pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", k, pc, 32'(4 * k)); end
            if (instr !== mem_word(32'(4 * k))) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", k, instr, mem_word(32'(4 * k))); end
            @(negedge clk);
        end
    endtask

    task automatic test_stall;
        do_reset(1, 1'b1);
        repeat (10) @(negedge clk);
        checks += 3;
        if (req_count !== 4) begin errors++; $display("FAIL stall_req_count got %0d want 4", req_count); end
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", instr_valid); end
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid got %b want 0", imem_req_valid); end
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks += 2;
            if (instr_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b want 1", k, instr_valid); end
            if (pc !== 32'(4 * k)) begin errors++; $display("FAIL drain_pc[%0d] got %h want %h", k, pc, 32'(4 * k)); end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect;
        bit seen;
        do_reset(3, 1'b1);
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        checks++;
        if (req_count !== 2) begin errors++; $display("FAIL redir_inflight got %0d want 2", req_count); end
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        checks += 3;
        if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL redir_req_valid got %b want 1", imem_req_valid); end
        if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %h want 100", imem_addr); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", instr_valid); end
        @(negedge clk);
        wait_valid(seen);
        checks += 3;
        if (!seen) begin errors++; $display("FAIL redir_timeout got no valid want valid"); end
        if (pc !== 32'h100) begin errors++; $display("FAIL redir_pc got %h want 100", pc); end
        if (instr !== mem_word(32'h100)) begin errors++; $display("FAIL redir_instr got %h want %h", instr, mem_word(32'h100)); end
    endtask

    task automatic test_misalign;
        bit seen;
        logic [31:0] exp_pc;
        do_reset(1, 1'b1);
        instr_ready = 1'b1;
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        begin
            int rc;
            checks += 3;
            if (fetch_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag got %b want 1", fetch_misalign); end
            if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_halt got %b want 0", imem_req_valid); end
            if (instr_valid !== 1'b0) begin errors++; $display("FAIL mis_flush got %b want 0", instr_valid); end
            rc = req_count;
            repeat (5) @(negedge clk);
            checks += 3;
            if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_hold_req got %b want 0", imem_req_valid); end
            if (req_count !== rc) begin errors++; $display("FAIL mis_hold_count got %0d want %0d", req_count, rc); end
            if (fetch_misalign !== 1'b1) begin errors++; $display("FAIL mis_hold_flag got %b want 1", fetch_misalign); end
            redirect_valid = 1'b1;
            redirect_pc    = 32'h200;
            @(negedge clk);
            redirect_valid = 1'b0;
            #1;
            exp_pc = 32'h200;
        end
`else
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL mis_flush got %b want 0", instr_valid); end
        exp_pc = 32'h100;
`endif
        checks += 3;
        if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", fetch_misalign); end
        if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL mis_resume got %b want 1", imem_req_valid); end
        if (imem_addr !== exp_pc) begin errors++; $display("FAIL mis_addr got %h want %h", imem_addr, exp_pc); end
        @(negedge clk);
        wait_valid(seen);
        checks += 2;
        if (!seen) begin errors++; $display("FAIL mis_timeout got no valid want valid"); end
        if (pc !== exp_pc) begin errors++; $display("FAIL mis_pc got %h want %h", pc, exp_pc); end
    endtask

    task automatic test_reset_mid;
        bit seen;
        do_reset(3, 1'b1);
        instr_ready = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        checks += 6;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_valid got %b want 0", imem_req_valid); end
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_addr got %h want 0", imem_addr); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", instr_valid); end
        if (pc !== 32'h0) begin errors++; $display("FAIL mid_pc got %h want 0", pc); end
        if (instr !== 32'h0) begin errors++; $display("FAIL mid_instr got %h want 0", instr); end
        if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mid_misalign got %b want 0", fetch_misalign); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 2;
        if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL mid_restart_req got %b want 1", imem_req_valid); end
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart_addr got %h want 0", imem_addr); end
        @(negedge clk);
        wait_valid(seen);
        checks += 3;
        if (!seen) begin errors++; $display("FAIL mid_timeout got no valid want valid"); end
        if (pc !== 32'h0) begin errors++; $display("FAIL mid_first_pc got %h want 0", pc); end
        if (instr !== 32'h3E80_8093) begin errors++; $display("FAIL mid_first_instr got %h want 3e808093", instr); end
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misalign();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
